// File: rtl/bullet_engine.sv
// Purpose: fixed pool of bullet slots; fire handshake, tick-driven motion, wall and tank-box collision.
// Latency: an accepted shot is visible one cycle later; hit_valid/hit_target lag the overlap cycle by one.
// Backpressure: fire_ready drops while the pool is full, during cooldown, game_over or clear.
module bullet_engine #(
    parameter int MAX_BULLETS   = 8,
    parameter int NUM_TARGETS   = 2,
    parameter int COORD_W       = 10,
    parameter int STEP          = 32,
    parameter int MOVE_DIV      = 3,
    parameter int FIRE_COOLDOWN = 4,
    parameter int ARENA_MAX     = 480,
    parameter int TANK_SIZE     = 32,
    parameter int BULLET_SIZE   = 8,
    parameter int MAP_DIM       = 16,
    parameter int TILE_SHIFT    = 5
) (
    input  logic                                     clk,
    input  logic                                     reset_n,
    input  logic                                     game_over,
    input  logic                                     clear,
    input  logic                                     tick,
    input  logic                                     fire_valid,
    output logic                                     fire_ready,
    input  logic [1:0]                               fire_dir,
    input  logic [COORD_W-1:0]                       fire_x,
    input  logic [COORD_W-1:0]                       fire_y,
    input  logic [NUM_TARGETS*COORD_W-1:0]           target_x,
    input  logic [NUM_TARGETS*COORD_W-1:0]           target_y,
    input  logic [MAP_DIM*MAP_DIM-1:0]               wall_map,
    output logic                                     hit_valid,
    output logic [NUM_TARGETS-1:0]                   hit_target,
    output logic [MAX_BULLETS-1:0]                   active_mask,
    output logic [$clog2(MAX_BULLETS+1)-1:0]         free_count,
    output logic [MAX_BULLETS*(2*COORD_W+12)-1:0]    bullet_state
);

    localparam int SW    = 2*COORD_W + 12;
    localparam int FC_W  = $clog2(MAX_BULLETS+1);
    localparam int CNT_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam int CD_W  = (FIRE_COOLDOWN > 0) ? $clog2(FIRE_COOLDOWN+1) : 1;
    localparam int MI_W  = $clog2(MAP_DIM*MAP_DIM);
    localparam logic [COORD_W:0]   BOX_B    = (COORD_W+1)'(BULLET_SIZE);
    localparam logic [COORD_W:0]   BOX_T    = (COORD_W+1)'(TANK_SIZE);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(MOVE_DIV-1);

    // Slot state
    logic [MAX_BULLETS-1:0] active_q, active_n;
    logic [COORD_W-1:0]     x_q   [MAX_BULLETS];
    logic [COORD_W-1:0]     x_n   [MAX_BULLETS];
    logic [COORD_W-1:0]     y_q   [MAX_BULLETS];
    logic [COORD_W-1:0]     y_n   [MAX_BULLETS];
    logic [1:0]             dir_q [MAX_BULLETS];
    logic [1:0]             dir_n [MAX_BULLETS];
    logic [2:0]             row_q [MAX_BULLETS];
    logic [2:0]             row_n [MAX_BULLETS];
    logic [2:0]             col_q [MAX_BULLETS];
    logic [2:0]             col_n [MAX_BULLETS];
    logic [CNT_W-1:0]       cnt_q [MAX_BULLETS];
    logic [CNT_W-1:0]       cnt_n [MAX_BULLETS];
    logic [CD_W-1:0]        cd_q, cd_n;
    logic [FC_W-1:0]        free_q, free_n;
    logic [NUM_TARGETS-1:0] hit_q, hit_n;
    logic                   hit_vld_q;

    // Per-slot collision / step results
    logic [NUM_TARGETS-1:0] cred     [MAX_BULLETS];
    logic [COORD_W:0]       step_res [MAX_BULLETS];
    logic [MAX_BULLETS-1:0] wall_hit;
    logic                   fire_acc;
    logic                   alloc_done;

    // Lowest-index overlapping target only; boxes compared in COORD_W+1 bits so sums cannot wrap.
    function automatic logic [NUM_TARGETS-1:0] credit_target(
        input logic [COORD_W-1:0]             bx,
        input logic [COORD_W-1:0]             by,
        input logic [NUM_TARGETS*COORD_W-1:0] tx_all,
        input logic [NUM_TARGETS*COORD_W-1:0] ty_all
    );
        logic [NUM_TARGETS-1:0] hit;
        logic [COORD_W:0]       tx;
        logic [COORD_W:0]       ty;
        logic [COORD_W:0]       ex;
        logic [COORD_W:0]       ey;
        hit = '0;
        ex  = {1'b0, bx};
        ey  = {1'b0, by};
        for (int t = 0; t < NUM_TARGETS; t++) begin
            tx = {1'b0, tx_all[t*COORD_W +: COORD_W]};
            ty = {1'b0, ty_all[t*COORD_W +: COORD_W]};
            if (hit == '0 && (ex + BOX_B) > tx && ex < (tx + BOX_T)
                          && (ey + BOX_B) > ty && ey < (ty + BOX_T))
                hit[t] = 1'b1;
        end
        return hit;
    endfunction

    // Tiles beyond the map edge count as solid.
    function automatic logic wall_at(
        input logic [COORD_W-1:0]         bx,
        input logic [COORD_W-1:0]         by,
        input logic [MAP_DIM*MAP_DIM-1:0] map
    );
        int              tx;
        int              ty;
        logic [MI_W-1:0] idx;
        tx  = int'(bx >> TILE_SHIFT);
        ty  = int'(by >> TILE_SHIFT);
        idx = '0;
        if (tx >= MAP_DIM || ty >= MAP_DIM)
            return 1'b1;
        idx = MI_W'(ty*MAP_DIM + tx);
        return map[idx];
    endfunction

    // Returns {dead, new_coord}; a dead step leaves the coordinate unchanged.
    function automatic logic [COORD_W:0] step_coord(input logic [COORD_W-1:0] c, input logic inc);
        int n;
        n = inc ? int'(c) + STEP : int'(c) - STEP;
        if (n < 0 || n >= ARENA_MAX)
            return {1'b1, c};
        return {1'b0, COORD_W'(n)};
    endfunction

    assign fire_ready = (~active_q != '0) && (cd_q == '0) && !game_over && !clear;
    assign fire_acc   = fire_valid && fire_ready;

    // Collision and candidate step for every slot, from current state.
    always_comb begin
        for (int i = 0; i < MAX_BULLETS; i++) begin
            cred[i]     = credit_target(x_q[i], y_q[i], target_x, target_y);
            wall_hit[i] = wall_at(x_q[i], y_q[i], wall_map);
            step_res[i] = step_coord(dir_q[i][1] ? x_q[i] : y_q[i], dir_q[i][0]);
        end
    end

    // Next slot state: clear, then hit > wall > move, then allocate the fire into the lowest free slot.
    always_comb begin
        active_n   = active_q;
        hit_n      = '0;
        alloc_done = 1'b0;
        free_n     = '0;
        cd_n       = cd_q;
        for (int i = 0; i < MAX_BULLETS; i++) begin
            x_n[i]   = x_q[i];
            y_n[i]   = y_q[i];
            dir_n[i] = dir_q[i];
            row_n[i] = row_q[i];
            col_n[i] = col_q[i];
            cnt_n[i] = cnt_q[i];
            if (clear) begin
                active_n[i] = 1'b0;
                cnt_n[i]    = '0;
            end else if (!game_over && active_q[i]) begin
                if (cred[i] != '0) begin
                    hit_n       = hit_n | cred[i];
                    active_n[i] = 1'b0;
                end else if (wall_hit[i]) begin
                    active_n[i] = 1'b0;
                end else if (tick) begin
                    if (cnt_q[i] == CNT_LAST) begin
                        cnt_n[i] = '0;
                        if (step_res[i][COORD_W])
                            active_n[i] = 1'b0;
                        else if (dir_q[i][1])
                            x_n[i] = step_res[i][COORD_W-1:0];
                        else
                            y_n[i] = step_res[i][COORD_W-1:0];
                    end else begin
                        cnt_n[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
            end
        end
        if (fire_acc) begin
            for (int i = 0; i < MAX_BULLETS; i++) begin
                if (!active_q[i] && !alloc_done) begin
                    alloc_done  = 1'b1;
                    active_n[i] = 1'b1;
                    x_n[i]      = fire_x;
                    y_n[i]      = fire_y;
                    dir_n[i]    = fire_dir;
                    row_n[i]    = 3'd0;
                    col_n[i]    = {1'b0, fire_dir};
                    cnt_n[i]    = '0;
                end
            end
        end
        if (fire_acc)
            cd_n = CD_W'(FIRE_COOLDOWN);
        else if (!game_over && cd_q != '0)
            cd_n = cd_q - CD_W'(1);
        for (int i = 0; i < MAX_BULLETS; i++)
            if (!active_n[i])
                free_n = free_n + FC_W'(1);
    end

    // State registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active_q  <= '0;
            cd_q      <= '0;
            free_q    <= FC_W'(MAX_BULLETS);
            hit_q     <= '0;
            hit_vld_q <= 1'b0;
            for (int i = 0; i < MAX_BULLETS; i++) begin
                x_q[i]   <= '0;
                y_q[i]   <= '0;
                dir_q[i] <= '0;
                row_q[i] <= '0;
                col_q[i] <= '0;
                cnt_q[i] <= '0;
            end
        end else begin
            active_q  <= active_n;
            cd_q      <= cd_n;
            free_q    <= free_n;
            hit_q     <= hit_n;
            hit_vld_q <= (hit_n != '0);
            for (int i = 0; i < MAX_BULLETS; i++) begin
                x_q[i]   <= x_n[i];
                y_q[i]   <= y_n[i];
                dir_q[i] <= dir_n[i];
                row_q[i] <= row_n[i];
                col_q[i] <= col_n[i];
                cnt_q[i] <= cnt_n[i];
            end
        end
    end

    assign active_mask = active_q;
    assign free_count  = free_q;
    assign hit_target  = hit_q;
    assign hit_valid   = hit_vld_q;

    // Render view for the sprite compositor, straight from the slot registers.
    always_comb begin
        for (int i = 0; i < MAX_BULLETS; i++)
            bullet_state[i*SW +: SW] = {1'b0, 2'b01, active_q[i], x_q[i], y_q[i],
                                        dir_q[i], row_q[i], col_q[i]};
    end

endmodule

// File: tb/tb_bullet_engine.sv
// Purpose: scoreboard bench for bullet_engine; expected hits queued at stimulus, popped on hit_valid.
// Latency: samples 1 time unit after each rising clk edge.
// Backpressure: fire requests wait (bounded) on fire_ready.
module tb_bullet_engine;
    localparam int MB = 8;
    localparam int NT = 2;
    localparam int CW = 10;
    localparam int SW = 2*CW + 12;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              game_over, clear, tick, fire_valid;
    logic              fire_ready;
    logic [1:0]        fire_dir;
    logic [CW-1:0]     fire_x, fire_y;
    logic [NT*CW-1:0]  target_x, target_y;
    logic [255:0]      wall_map;
    logic              hit_valid;
    logic [NT-1:0]     hit_target;
    logic [MB-1:0]     active_mask;
    logic [3:0]        free_count;
    logic [MB*SW-1:0]  bullet_state;

    int checks = 0;
    int errors = 0;
    logic [NT-1:0] exp_hits[$];

    always #5 clk = ~clk;

    bullet_engine dut (
        .clk(clk), .reset_n(reset_n), .game_over(game_over), .clear(clear), .tick(tick),
        .fire_valid(fire_valid), .fire_ready(fire_ready), .fire_dir(fire_dir),
        .fire_x(fire_x), .fire_y(fire_y), .target_x(target_x), .target_y(target_y),
        .wall_map(wall_map), .hit_valid(hit_valid), .hit_target(hit_target),
        .active_mask(active_mask), .free_count(free_count), .bullet_state(bullet_state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] slot_word(input int i);
        return bullet_state[i*SW +: SW];
    endfunction
    function automatic logic [31:0] slot_x(input int i);
        return 32'(bullet_state[i*SW+18 +: CW]);
    endfunction
    function automatic logic [31:0] slot_y(input int i);
        return 32'(bullet_state[i*SW+8 +: CW]);
    endfunction
    function automatic logic [31:0] slot_act(input int i);
        return 32'(bullet_state[i*SW+28]);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        tick = 1'b1;
        repeat (n) step();
        tick = 1'b0;
    endtask

    task automatic set_target(input int t, input int x, input int y);
        target_x[t*CW +: CW] = CW'(x);
        target_y[t*CW +: CW] = CW'(y);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) step();
        reset_n = 1'b1;
    endtask

    task automatic fire_one(input int x, input int y, input int d);
        int n;
        n = 0;
        while (!fire_ready && n < 20) begin
            step();
            n++;
        end
        if (!fire_ready)
            check("fire_wait_timeout", 32'(fire_ready), 1);
        fire_x     = CW'(x);
        fire_y     = CW'(y);
        fire_dir   = 2'(d);
        fire_valid = 1'b1;
        step();
        fire_valid = 1'b0;
    endtask

    // Hit monitor: every pulse must match the next queued expectation.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (hit_valid || hit_target != '0) begin
                check("hit_pending", 32'(exp_hits.size() != 0), 1);
                if (exp_hits.size() != 0)
                    check("hit_target", 32'(hit_target), 32'(exp_hits.pop_front()));
                check("hit_valid", 32'(hit_valid), 1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int acc_cnt, first, last;
        reset_n = 1'b0; game_over = 1'b0; clear = 1'b0; tick = 1'b0;
        fire_valid = 1'b0; fire_dir = 2'd0; fire_x = '0; fire_y = '0;
        wall_map = '0; target_x = '0; target_y = '0;
        set_target(0, 1000, 1000);
        set_target(1, 1000, 1000);
        do_reset();

        // Reset state
        check("rst_mask", 32'(active_mask), 0);
        check("rst_free", 32'(free_count), 8);
        check("rst_ready", 32'(fire_ready), 1);
        check("rst_hit", 32'(hit_valid), 0);
        check("rst_slot0", slot_word(0), 32'h2000_0000);

        // Fire held six cycles against a 4-cycle cooldown
        acc_cnt = 0; first = -1; last = -1;
        fire_x = 10'd100; fire_y = 10'd200; fire_dir = 2'd2; fire_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (fire_ready) begin
                acc_cnt++;
                if (first < 0) first = c;
                last = c;
            end
            step();
        end
        fire_valid = 1'b0;
        check("fire_accepts", 32'(acc_cnt), 2);
        check("fire_gap", 32'(last - first), 5);
        check("fire_mask", 32'(active_mask), 32'h03);
        check("fire_free", 32'(free_count), 6);
        check("slot1_state", slot_word(1),
              {1'b0, 2'b01, 1'b1, 10'd100, 10'd200, 2'd2, 3'd0, 3'd2});

        // Reset mid-flight with three bullets live
        fire_one(300, 300, 1);
        tick_n(2);
        check("pre_rst_mask", 32'(active_mask), 32'h07);
        reset_n = 1'b0;
        #1;
        check("async_rst_mask", 32'(active_mask), 0);
        step();
        reset_n = 1'b1;
        check("post_rst_mask", 32'(active_mask), 0);
        check("post_rst_free", 32'(free_count), 8);
        check("post_rst_ready", 32'(fire_ready), 1);

        // Movement right on an empty map
        fire_one(64, 64, 3);
        check("move_load", slot_word(0),
              {1'b0, 2'b01, 1'b1, 10'd64, 10'd64, 2'd3, 3'd0, 3'd3});
        tick_n(3);
        check("move_x_3", slot_x(0), 96);
        tick_n(3);
        check("move_x_6", slot_x(0), 128);
        tick_n(32);
        check("move_x_448", slot_x(0), 448);
        check("move_alive_448", slot_act(0), 1);
        tick_n(1);
        check("move_edge_dead", slot_act(0), 0);
        check("move_edge_keep", slot_x(0), 448);

        // Walls: tile (row 2, col 4) is solid
        do_reset();
        wall_map[2*16+4] = 1'b1;
        fire_one(64, 64, 3);
        fire_one(64, 96, 3);
        tick_n(6);
        check("wall_a_x", slot_x(0), 128);
        check("wall_a_alive", slot_act(0), 1);
        check("wall_b_x", slot_x(1), 128);
        tick_n(1);
        check("wall_a_dead", slot_act(0), 0);
        check("wall_b_alive", slot_act(1), 1);
        tick_n(2);
        check("wall_b_pass", slot_x(1), 160);
        wall_map = '0;

        // Targets: both tanks on the same box, lowest index credited
        do_reset();
        set_target(0, 160, 64);
        set_target(1, 160, 64);
        fire_one(64, 64, 3);
        tick_n(9);
        check("tgt_reach", slot_x(0), 160);
        exp_hits.push_back(2'b01);
        step();
        check("tgt_freed", slot_act(0), 0);
        step();
        check("tgt_one_pulse", 32'(hit_valid), 0);

        // Two bullets hitting target 1 on the same edge
        set_target(0, 1000, 1000);
        set_target(1, 1000, 1000);
        fire_one(200, 200, 0);
        fire_one(210, 210, 0);
        check("dual_live", 32'(active_mask), 32'h03);
        exp_hits.push_back(2'b10);
        set_target(1, 200, 200);
        step();
        check("dual_freed", 32'(active_mask), 0);
        set_target(1, 1000, 1000);
        repeat (2) step();

        // Full pool, then one dies
        do_reset();
        for (int i = 0; i < 8; i++)
            fire_one(40 + 40*i, 300, 0);
        check("full_mask", 32'(active_mask), 32'hFF);
        check("full_free", 32'(free_count), 0);
        repeat (5) step();
        check("full_ready", 32'(fire_ready), 0);
        exp_hits.push_back(2'b01);
        set_target(0, 160, 300);
        step();
        check("one_died_ready", 32'(fire_ready), 1);
        check("one_died_mask", 32'(active_mask), 32'hF7);
        check("one_died_free", 32'(free_count), 1);
        set_target(0, 1000, 1000);
        fire_one(160, 300, 0);
        check("refill_mask", 32'(active_mask), 32'hFF);

        // Freeze: ticks ignored, counters held
        game_over = 1'b1;
        tick_n(6);
        check("freeze_y", slot_y(0), 300);
        check("freeze_ready", 32'(fire_ready), 0);
        check("freeze_mask", 32'(active_mask), 32'hFF);
        game_over = 1'b0;
        tick_n(2);
        check("thaw_y_hold", slot_y(0), 300);
        tick_n(1);
        check("thaw_y_step", slot_y(0), 268);

        // Clear overrides game_over
        game_over = 1'b1;
        clear = 1'b1;
        check("clear_ready", 32'(fire_ready), 0);
        step();
        check("clear_mask", 32'(active_mask), 0);
        check("clear_free", 32'(free_count), 8);
        clear = 1'b0;
        game_over = 1'b0;
        repeat (2) step();
        check("clear_ready_back", 32'(fire_ready), 1);

        repeat (3) step();
        check("sb_drain", 32'(exp_hits.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
